pipeline_hazard_sequencer: RTL

//  Central stall/flush sequencer for the 5-stage RV32I pipeline (F/D/E/M/W).

---
 rtl/pipeline_hazard_sequencer_if.sv | 44 ++++
 rtl/pipeline_hazard_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_sequencer_if.sv
// pipeline_hazard_sequencer_if
// Bundles the pipeline-facing signals of the hazard sequencer.
//   master : pipeline side. It drives hazard sources and the memory ack,
//            and observes the stage controls and the counters.
//   slave  : sequencer side.
// Ports/signals:
//   ResultSrcE, RD_E, RS1_D, RS2_D, PCSrcE, MemReqM, dmem_ack : hazard sources
//   dmem_req, Stall{F,D,E,M}, Flush{D,E,W}, err                : controls/status
//   cnt_lw, cnt_mem, cnt_flush                                 : event counters
interface pipeline_hazard_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [1:0]       ResultSrcE;
    logic [4:0]       RD_E;
    logic [4:0]       RS1_D;
    logic [4:0]       RS2_D;
    logic             PCSrcE;
    logic             MemReqM;
    logic             dmem_ack;
    logic             dmem_req;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushW;
    logic             err;
    logic [CNT_W-1:0] cnt_lw;
    logic [CNT_W-1:0] cnt_mem;
    logic [CNT_W-1:0] cnt_flush;

    modport master (
        output ResultSrcE, RD_E, RS1_D, RS2_D, PCSrcE, MemReqM, dmem_ack,
        input  dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  err, cnt_lw, cnt_mem, cnt_flush
    );

    modport slave (
        input  ResultSrcE, RD_E, RS1_D, RS2_D, PCSrcE, MemReqM, dmem_ack,
        output dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output err, cnt_lw, cnt_mem, cnt_flush
    );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// pipeline_hazard_sequencer
// Central stall/flush sequencer for a 5-stage RV32I pipeline. It merges three
// hazard sources into one prioritised set of stage controls:
//   1. a data-memory wait
//   2. an E-stage redirect
//   3. a load-use interlock
// It also keeps saturating hazard event counters.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   hif : pipeline_hazard_sequencer_if.slave (hazard sources, controls, counters)
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | no access outstanding; dmem_req follows MemReqM
// DWAIT | access outstanding, memory has not acked yet; pipeline frozen
// ERR   | memory timed out; pipeline frozen until reset
module pipeline_hazard_sequencer #(
    parameter int WAIT_W         = 8,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int CNT_W          = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    pipeline_hazard_sequencer_if.slave   hif
);

    typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, ERR = 2'd2} stateT;

    stateT             state;
    stateT             stateNext;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] waitNext;
    logic              errReg;

    logic              lwHazard;
    logic              memStall;
    logic              flushWin;
    logic              lwWin;
    logic [CNT_W-1:0]  cntLw;
    logic [CNT_W-1:0]  cntMem;
    logic [CNT_W-1:0]  cntFlush;

    assign lwHazard = (hif.ResultSrcE == 2'b01) && (hif.RD_E != 5'd0) &&
                      ((hif.RS1_D == hif.RD_E) || (hif.RS2_D == hif.RD_E));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitNext;
        end
    end

    // The wait count includes the RUN cycle that first missed. The FSM
    // enters ERR on the cycle where that count reaches TIMEOUT_CYCLES.
    always_comb begin
        stateNext = state;
        waitNext  = waitCnt;
        case (state)
            RUN: begin
                if (hif.MemReqM && !hif.dmem_ack) begin
                    stateNext = DWAIT;
                    waitNext  = WAIT_W'(1);
                end
            end
            DWAIT: begin
                if (hif.dmem_ack) begin
                    stateNext = RUN;
                    waitNext  = '0;
                end else begin
                    waitNext = waitCnt + WAIT_W'(1);
                    if (waitNext >= WAIT_W'(TIMEOUT_CYCLES)) stateNext = ERR;
                end
            end
            ERR:     stateNext = ERR;
            default: stateNext = RUN;
        endcase
    end

    // The controls are gated with rst so that every output is 0 while
    // reset is held, even though hazard inputs may be live.
    always_comb begin
        memStall     = 1'b0;
        hif.dmem_req = 1'b0;
        case (state)
            RUN: begin
                memStall     = hif.MemReqM && !hif.dmem_ack;
                hif.dmem_req = hif.MemReqM;
            end
            DWAIT: begin
                memStall     = !hif.dmem_ack;
                hif.dmem_req = 1'b1;
            end
            ERR:     memStall = 1'b1;
            default: memStall = 1'b0;
        endcase
        memStall     = memStall && rst;
        hif.dmem_req = hif.dmem_req && rst;

        flushWin = rst && !memStall && hif.PCSrcE;
        lwWin    = rst && !memStall && !hif.PCSrcE && lwHazard;

        // While frozen, a redirect in E stays held and is applied on the
        // release cycle. FlushW bubbles W so the stalled M result is not
        // retired twice.
        hif.StallF = memStall || lwWin;
        hif.StallD = memStall || lwWin;
        hif.StallE = memStall;
        hif.StallM = memStall;
        hif.FlushW = memStall;
        hif.FlushD = flushWin;
        hif.FlushE = flushWin || lwWin;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            errReg   <= 1'b0;
            cntLw    <= '0;
            cntMem   <= '0;
            cntFlush <= '0;
        end else begin
            if (stateNext == ERR) errReg <= 1'b1;
            if (lwWin && (cntLw != '1))       cntLw    <= cntLw + CNT_W'(1);
            if (flushWin && (cntFlush != '1)) cntFlush <= cntFlush + CNT_W'(1);
            if (memStall && (state != ERR) && (cntMem != '1))
                cntMem <= cntMem + CNT_W'(1);
        end
    end

    assign hif.err       = errReg;
    assign hif.cnt_lw    = cntLw;
    assign hif.cnt_mem   = cntMem;
    assign hif.cnt_flush = cntFlush;

endmodule
